// File: rtl/mul_pkg.sv
// Shared types and constants for the multiply sequencer and its shift-add core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mul_pkg;

    localparam int DATA_W    = 16;
    localparam int PROD_W    = 2 * DATA_W;
    localparam int MUL_ITERS = 16;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } mul_state_t;

    typedef enum logic [1:0] {
        MUL_I  = 2'd0,   // unsigned, immediate
        MUL_R  = 2'd1,   // unsigned, register
        MUL_SI = 2'd2,   // signed, immediate
        MUL_SR = 2'd3    // signed, register
    } mul_type_t;

    function automatic logic is_reg_type(input mul_type_t t);
        return (t == MUL_R) || (t == MUL_SR);
    endfunction

    function automatic logic is_signed_type(input mul_type_t t);
        return (t == MUL_SI) || (t == MUL_SR);
    endfunction

    // Magnitude of a possibly-signed operand; -32768 maps to 0x8000, which
    // is still correct when the result is read as unsigned.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic sgn);
        return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_sa_core.sv
// Unsigned 16x16 shift-add multiplier: fixed 16 iterations, one per clock.
// Latency: start edge loads operands; done is high during the 16th iteration
//          cycle with product showing that iteration's result.
// Backpressure: none; start is only honoured by the owner while idle.
// Ports: clk, rst (sync active-low), start, a_mag/b_mag (operand magnitudes),
//        done (final-iteration strobe), product (32-bit result, valid with done).
module mul_sa_core
    import mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a_mag,
    input  logic [DATA_W-1:0] b_mag,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;
    logic              running;
    logic [PROD_W-1:0] acc_nxt;

    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
    // done marks the cycle whose edge performs the last iteration, so the
    // owner can register the result on that same edge.
    assign done    = running && (cnt == CNT_W'(MUL_ITERS - 1));
    assign product = acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            mcand   <= {{DATA_W{1'b0}}, a_mag};
            mplier  <= b_mag;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 5'd1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply sequencer: fetch operands, run shift-add core, write back.
// Latency: trigger cycle T -> FETCH T+1, EXEC T+2..T+17, WRITE T+18 (19 cycles).
// Backpressure: stall holds decode from the trigger cycle to WRITE; triggers while busy are dropped.
// Ports: clk, rst (sync active-low); mul_trigger/mul_type/set_flags/dest_reg/
//        src1_reg/src2_reg/imm from decode; rf_rd_addr1/2 + rf_rd_data1/2 read
//        ports; rf_wr_en/addr/data write port; stall, busy, done; flag_we/n/z.
module mul_sequencer
    import mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mul_trigger,
    input  logic [1:0]        mul_type,
    input  logic              set_flags,
    input  logic [3:0]        dest_reg,
    input  logic [3:0]        src1_reg,
    input  logic [3:0]        src2_reg,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rf_rd_data1,
    input  logic [DATA_W-1:0] rf_rd_data2,
    output logic [3:0]        rf_rd_addr1,
    output logic [3:0]        rf_rd_addr2,
    output logic              rf_wr_en,
    output logic [3:0]        rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic              flag_we,
    output logic              flag_n,
    output logic              flag_z
);

    mul_state_t        state;
    mul_type_t         cap_type;
    logic              cap_flags;
    logic [3:0]        cap_dest;
    logic [DATA_W-1:0] cap_imm;
    logic              negate;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_signed;
    logic              negate_nxt;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              core_start;
    logic              core_done;
    logic [PROD_W-1:0] core_product;
    logic [PROD_W-1:0] result;
    logic [DATA_W-1:0] result_lo;

    // Operand selection while in FETCH; read data is combinational from the RF.
    assign op_a       = rf_rd_data1;
    assign op_b       = is_reg_type(cap_type) ? rf_rd_data2 : cap_imm;
    assign op_signed  = is_signed_type(cap_type);
    assign a_mag      = magnitude(op_a, op_signed);
    assign b_mag      = magnitude(op_b, op_signed);
    assign negate_nxt = op_signed && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
    assign core_start = (state == FETCH);

    assign result     = negate ? (~core_product + 32'd1) : core_product;
    assign result_lo  = result[DATA_W-1:0];

    // Combinational so decode is frozen in the very cycle the trigger is seen.
    assign stall = busy || ((state == IDLE) && mul_trigger);

    mul_sa_core u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (core_start),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .done    (core_done),
        .product (core_product)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cap_type    <= MUL_I;
            cap_flags   <= 1'b0;
            cap_dest    <= '0;
            cap_imm     <= '0;
            negate      <= 1'b0;
            rf_rd_addr1 <= '0;
            rf_rd_addr2 <= '0;
            rf_wr_en    <= 1'b0;
            rf_wr_addr  <= '0;
            rf_wr_data  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            flag_we     <= 1'b0;
            flag_n      <= 1'b0;
            flag_z      <= 1'b0;
        end else begin
            // Single-cycle strobes default low.
            rf_wr_en <= 1'b0;
            done     <= 1'b0;
            flag_we  <= 1'b0;

            case (state)
                IDLE: begin
                    if (mul_trigger) begin
                        cap_type    <= mul_type_t'(mul_type);
                        cap_flags   <= set_flags;
                        cap_dest    <= dest_reg;
                        cap_imm     <= imm;
                        // Read addresses are registered here so they are
                        // stable for the whole FETCH cycle.
                        rf_rd_addr1 <= src1_reg;
                        rf_rd_addr2 <= src2_reg;
                        busy        <= 1'b1;
                        state       <= FETCH;
                    end
                end

                FETCH: begin
                    negate      <= negate_nxt;
                    rf_rd_addr1 <= '0;
                    rf_rd_addr2 <= '0;
                    state       <= EXEC;
                end

                EXEC: begin
                    if (core_done) begin
                        rf_wr_en   <= 1'b1;
                        rf_wr_addr <= cap_dest;
                        rf_wr_data <= result_lo;
                        done       <= 1'b1;
                        if (cap_flags) begin
                            flag_we <= 1'b1;
                            flag_n  <= result_lo[DATA_W-1];
                            flag_z  <= (result_lo == '0);
                        end
                        state <= WRITE;
                    end
                end

                WRITE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
